// File: rtl/ex_stg_if.sv
// rtl/ex_stg_if.sv - EX stage bundle: instruction in, stall/flush control, EX/MEM register out
// Ports (all in the bundle):
//   upstream : valid_in, opcode_in[3:0], operand_a[7:0], operand_b[7:0], rd_in[2:0], ready_out
//   control  : stall_in, flush
//   EX/MEM   : valid_out, opcode_out[3:0], rd_out[2:0], alu_output[7:0], address_output[7:0],
//              store_data_output[7:0], we_output, zero_flag, carry_flag
//   EX_STG_FWD_EN only: fwd_data[7:0], fwd_sel_a, fwd_sel_b
// master = producer/consumer side (pipeline or bench), slave = the EX stage.
interface ex_stg_if;
    logic       valid_in;
    logic [3:0] opcode_in;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [2:0] rd_in;
    logic       stall_in;
    logic       flush;
    logic       ready_out;
    logic       valid_out;
    logic [3:0] opcode_out;
    logic [2:0] rd_out;
    logic [7:0] alu_output;
    logic [7:0] address_output;
    logic [7:0] store_data_output;
    logic       we_output;
    logic       zero_flag;
    logic       carry_flag;
`ifdef EX_STG_FWD_EN
    logic [7:0] fwd_data;
    logic       fwd_sel_a;
    logic       fwd_sel_b;

    modport master (
        output valid_in, opcode_in, operand_a, operand_b, rd_in, stall_in, flush,
        output fwd_data, fwd_sel_a, fwd_sel_b,
        input  ready_out, valid_out, opcode_out, rd_out, alu_output, address_output,
        input  store_data_output, we_output, zero_flag, carry_flag
    );
    modport slave (
        input  valid_in, opcode_in, operand_a, operand_b, rd_in, stall_in, flush,
        input  fwd_data, fwd_sel_a, fwd_sel_b,
        output ready_out, valid_out, opcode_out, rd_out, alu_output, address_output,
        output store_data_output, we_output, zero_flag, carry_flag
    );
`else
    modport master (
        output valid_in, opcode_in, operand_a, operand_b, rd_in, stall_in, flush,
        input  ready_out, valid_out, opcode_out, rd_out, alu_output, address_output,
        input  store_data_output, we_output, zero_flag, carry_flag
    );
    modport slave (
        input  valid_in, opcode_in, operand_a, operand_b, rd_in, stall_in, flush,
        output ready_out, valid_out, opcode_out, rd_out, alu_output, address_output,
        output store_data_output, we_output, zero_flag, carry_flag
    );
`endif
endinterface

// File: rtl/ex_stg.sv
// rtl/ex_stg.sv - execute stage: 8-bit ALU, iterative shift-add multiplier, EX/MEM register
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ex_stg_if.slave (instruction in, stall/flush, EX/MEM register and flags out)
// Optional feature: define EX_STG_FWD_EN to add operand forwarding (fwd_data, fwd_sel_a, fwd_sel_b).
module ex_stg (
    input logic   clk,
    input logic   rst,
    ex_stg_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_NOT   = 4'h6;
    localparam logic [3:0] OP_MUL   = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_MOV   = 4'hA;
    localparam logic [3:0] OP_LOAD  = 4'hD;
    localparam logic [3:0] OP_STORE = 4'hE;

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [2:0]  mul_rd;
    logic [15:0] mul_acc;

    logic        valid_q;
    logic [3:0]  opcode_q;
    logic [2:0]  rd_q;
    logic [7:0]  alu_q;
    logic [7:0]  addr_q;
    logic [7:0]  sd_q;
    logic        we_q;
    logic        zf_q;
    logic        cf_q;

    logic [7:0]  eff_a;
    logic [7:0]  eff_b;
    logic [8:0]  sum9;
    logic [7:0]  alu_res;
    logic        alu_carry;
    logic        flags_upd;
    logic [15:0] partial;
    logic [15:0] mul_next;
    logic [15:0] mul_prod;
    logic        ready;
    logic        accept;

`ifdef EX_STG_FWD_EN
    assign eff_a = bus.fwd_sel_a ? bus.fwd_data : bus.operand_a;
    assign eff_b = bus.fwd_sel_b ? bus.fwd_data : bus.operand_b;
`else
    assign eff_a = bus.operand_a;
    assign eff_b = bus.operand_b;
`endif

    assign sum9 = {1'b0, eff_a} + {1'b0, eff_b};

    always_comb begin
        alu_res   = 8'h00;
        alu_carry = 1'b0;
        flags_upd = 1'b0;
        case (bus.opcode_in)
            OP_ADD:   begin alu_res = sum9[7:0];      alu_carry = sum9[8];        flags_upd = 1'b1; end
            OP_SUB:   begin alu_res = eff_a - eff_b;  alu_carry = (eff_a < eff_b); flags_upd = 1'b1; end
            OP_AND:   begin alu_res = eff_a & eff_b;  flags_upd = 1'b1; end
            OP_OR:    begin alu_res = eff_a | eff_b;  flags_upd = 1'b1; end
            OP_XOR:   begin alu_res = eff_a ^ eff_b;  flags_upd = 1'b1; end
            OP_NOT:   begin alu_res = ~eff_a;         flags_upd = 1'b1; end
            OP_SHL:   begin alu_res = {eff_a[6:0], 1'b0}; alu_carry = eff_a[7]; flags_upd = 1'b1; end
            OP_SHR:   begin alu_res = {1'b0, eff_a[7:1]}; alu_carry = eff_a[0]; flags_upd = 1'b1; end
            OP_MOV:   alu_res = eff_b;
            // Memory ops pass the address through the result field as well.
            OP_LOAD:  alu_res = eff_b;
            OP_STORE: alu_res = eff_b;
            default:  alu_res = 8'h00;
        endcase
    end

    // One shift-add step: add A shifted by the current bit position of B.
    assign partial  = mul_b[cnt] ? ({8'h00, mul_a} << cnt) : 16'h0000;
    assign mul_next = mul_acc + partial;
    // In MUL the final step and the write share an edge; in HOLD the product is already complete.
    assign mul_prod = (state == ST_HOLD) ? mul_acc : mul_next;

    assign ready  = (state == ST_IDLE) && !bus.stall_in && !rst;
    assign accept = bus.valid_in && ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            mul_a    <= 8'h00;
            mul_b    <= 8'h00;
            mul_rd   <= 3'd0;
            mul_acc  <= 16'h0000;
            valid_q  <= 1'b0;
            opcode_q <= 4'h0;
            rd_q     <= 3'd0;
            alu_q    <= 8'h00;
            addr_q   <= 8'h00;
            sd_q     <= 8'h00;
            we_q     <= 1'b0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            state   <= ST_IDLE;
            cnt     <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus.stall_in) begin
                        if (accept && bus.opcode_in == OP_MUL) begin
                            state   <= ST_MUL;
                            mul_a   <= eff_a;
                            mul_b   <= eff_b;
                            mul_rd  <= bus.rd_in;
                            mul_acc <= 16'h0000;
                            cnt     <= 3'd0;
                            valid_q <= 1'b0;
                            we_q    <= 1'b0;
                        end else if (accept) begin
                            valid_q  <= 1'b1;
                            opcode_q <= bus.opcode_in;
                            rd_q     <= bus.rd_in;
                            alu_q    <= alu_res;
                            addr_q   <= eff_b;
                            sd_q     <= eff_a;
                            we_q     <= (bus.opcode_in == OP_STORE);
                            if (flags_upd) begin
                                zf_q <= (alu_res == 8'h00);
                                cf_q <= alu_carry;
                            end
                        end else begin
                            valid_q <= 1'b0;
                            we_q    <= 1'b0;
                        end
                    end
                end
                ST_MUL, ST_HOLD: begin
                    // The multiplier keeps stepping through a stall; only the write waits.
                    if (state == ST_MUL) begin
                        mul_acc <= mul_next;
                        cnt     <= cnt + 3'd1;
                    end
                    if ((state == ST_HOLD || cnt == 3'd7) && !bus.stall_in) begin
                        state    <= ST_IDLE;
                        cnt      <= 3'd0;
                        valid_q  <= 1'b1;
                        opcode_q <= OP_MUL;
                        rd_q     <= mul_rd;
                        alu_q    <= mul_prod[7:0];
                        addr_q   <= mul_b;
                        sd_q     <= mul_a;
                        we_q     <= 1'b0;
                        zf_q     <= (mul_prod[7:0] == 8'h00);
                        cf_q     <= (mul_prod[15:8] != 8'h00);
                    end else if (state == ST_MUL && cnt == 3'd7) begin
                        state <= ST_HOLD;
                    end else if (!bus.stall_in) begin
                        valid_q <= 1'b0;
                        we_q    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready_out         = ready;
    assign bus.valid_out         = valid_q;
    assign bus.opcode_out        = opcode_q;
    assign bus.rd_out            = rd_q;
    assign bus.alu_output        = alu_q;
    assign bus.address_output    = addr_q;
    assign bus.store_data_output = sd_q;
    assign bus.we_output         = we_q;
    assign bus.zero_flag         = zf_q;
    assign bus.carry_flag        = cf_q;
endmodule

// File: tb/tb_ex_stg.sv
// tb/tb_ex_stg.sv - directed self-checking bench for ex_stg
module tb_ex_stg;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    ex_stg_if bus ();

    ex_stg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.valid_in  = 1'b1;
        bus.opcode_in = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.rd_in     = 3'd5;
        step();
        bus.valid_in  = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] alu, input logic zf, input logic cf);
        chk({tag, "_valid"}, {15'd0, bus.valid_out}, 16'd1);
        chk({tag, "_alu"},   {8'd0, bus.alu_output}, {8'd0, alu});
        chk({tag, "_zf"},    {15'd0, bus.zero_flag}, {15'd0, zf});
        chk({tag, "_cf"},    {15'd0, bus.carry_flag}, {15'd0, cf});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.valid_in  = 1'b0;
        bus.opcode_in = 4'h0;
        bus.operand_a = 8'h00;
        bus.operand_b = 8'h00;
        bus.rd_in     = 3'd0;
        bus.stall_in  = 1'b0;
        bus.flush     = 1'b0;
`ifdef EX_STG_FWD_EN
        bus.fwd_data  = 8'h00;
        bus.fwd_sel_a = 1'b0;
        bus.fwd_sel_b = 1'b0;
`endif
        step();
        step();
        chk("rst_valid", {15'd0, bus.valid_out}, 16'd0);
        chk("rst_alu",   {8'd0, bus.alu_output}, 16'd0);
        chk("rst_flags", {14'd0, bus.zero_flag, bus.carry_flag}, 16'd0);
        chk("rst_ready", {15'd0, bus.ready_out}, 16'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {15'd0, bus.ready_out}, 16'd1);

        issue(4'h1, 8'hF0, 8'h10);
        chk_res("add_wrap", 8'h00, 1'b1, 1'b1);
        chk("add_rd", {13'd0, bus.rd_out}, 16'd5);

        // Stalled stage must not accept and must freeze the register.
        bus.stall_in = 1'b1;
        bus.valid_in = 1'b1;
        bus.opcode_in = 4'h1;
        bus.operand_a = 8'h01;
        bus.operand_b = 8'h01;
        #1;
        chk("stall_ready", {15'd0, bus.ready_out}, 16'd0);
        step();
        chk_res("stall_hold", 8'h00, 1'b1, 1'b1);
        bus.stall_in = 1'b0;
        bus.valid_in = 1'b0;
        step();
        chk("bubble_valid", {15'd0, bus.valid_out}, 16'd0);

        issue(4'hE, 8'hA9, 8'h01);
        chk("st_we",   {15'd0, bus.we_output}, 16'd1);
        chk("st_addr", {8'd0, bus.address_output}, 16'h01);
        chk("st_data", {8'd0, bus.store_data_output}, 16'hA9);
        issue(4'hD, 8'h00, 8'h01);
        chk("ld_we",   {15'd0, bus.we_output}, 16'd0);
        chk("ld_op",   {12'd0, bus.opcode_out}, 16'hD);
        chk("ld_flags_kept", {14'd0, bus.zero_flag, bus.carry_flag}, 16'b11);

        issue(4'h6, 8'h0F, 8'h00);
        chk_res("not", 8'hF0, 1'b0, 1'b0);
        issue(4'h5, 8'hFF, 8'hFF);
        chk_res("xor", 8'h00, 1'b1, 1'b0);
        issue(4'hA, 8'h00, 8'h5A);
        chk_res("mov", 8'h5A, 1'b1, 1'b0);
        issue(4'h8, 8'h81, 8'h00);
        chk_res("shl", 8'h02, 1'b0, 1'b1);
        issue(4'h9, 8'h01, 8'h00);
        chk_res("shr", 8'h00, 1'b1, 1'b1);

        // 0x13 * 0x0B = 0x00D1
        issue(4'h7, 8'h13, 8'h0B);
        chk("mul_bubble", {15'd0, bus.valid_out}, 16'd0);
        chk("mul_ready0", {15'd0, bus.ready_out}, 16'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("mul_busy", {15'd0, bus.ready_out}, 16'd0);
        end
        step();
        chk_res("mul", 8'hD1, 1'b0, 1'b0);
        chk("mul_op", {12'd0, bus.opcode_out}, 16'h7);
        chk("mul_ready1", {15'd0, bus.ready_out}, 16'd1);

        issue(4'h2, 8'h03, 8'h05);
        chk_res("sub", 8'hFE, 1'b0, 1'b1);

        // 0x20 * 0x10 = 0x0200: low byte 0, carry set. Stall over edges 5..12.
        issue(4'h7, 8'h20, 8'h10);
        for (int i = 1; i <= 4; i++) step();
        bus.stall_in = 1'b1;
        for (int i = 5; i <= 12; i++) step();
        chk("hold_valid", {15'd0, bus.valid_out}, 16'd0);
        chk("hold_alu",   {8'd0, bus.alu_output}, 16'hFE);
        chk("hold_flags", {14'd0, bus.zero_flag, bus.carry_flag}, 16'b01);
        bus.stall_in = 1'b0;
        #1;
        chk("hold_ready", {15'd0, bus.ready_out}, 16'd0);
        step();
        chk_res("hold_mul", 8'h00, 1'b1, 1'b1);

        // Flush on multiplier step 4 aborts it.
        issue(4'h7, 8'h13, 8'h0B);
        for (int i = 1; i <= 3; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_valid", {15'd0, bus.valid_out}, 16'd0);
        chk("flush_ready", {15'd0, bus.ready_out}, 16'd1);
        chk("flush_flags", {14'd0, bus.zero_flag, bus.carry_flag}, 16'b11);
        for (int i = 0; i < 6; i++) step();
        chk("flush_abort", {15'd0, bus.valid_out}, 16'd0);

`ifdef EX_STG_FWD_EN
        bus.fwd_sel_a = 1'b1;
        bus.fwd_data  = 8'h22;
        issue(4'h1, 8'h00, 8'h01);
        bus.fwd_sel_a = 1'b0;
        chk_res("fwd_add", 8'h23, 1'b0, 1'b0);
`endif

        issue(4'h1, 8'h05, 8'h01);
        chk_res("pre_rst_add", 8'h06, 1'b0, 1'b0);
        issue(4'h7, 8'hFF, 8'hFF);
        for (int i = 1; i <= 3; i++) step();
        rst = 1'b1;
        step();
        chk("mrst_valid", {15'd0, bus.valid_out}, 16'd0);
        chk("mrst_alu",   {8'd0, bus.alu_output}, 16'd0);
        chk("mrst_addr",  {8'd0, bus.address_output}, 16'd0);
        chk("mrst_sd",    {8'd0, bus.store_data_output}, 16'd0);
        chk("mrst_op",    {12'd0, bus.opcode_out}, 16'd0);
        chk("mrst_ready", {15'd0, bus.ready_out}, 16'd0);
        rst = 1'b0;
        #1;
        chk("mrst_ready1", {15'd0, bus.ready_out}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ex_stg.md
EX_STG -- requirements
Module: ex_stg

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have inputs:
- valid_in (1): upstream instruction valid.
- opcode_in (4): instruction opcode.
- operand_a (8): source A; store data.
- operand_b (8): source B; memory address for load/store.
- rd_in (3): destination register.
REQ-004 SHALL have control inputs:
- stall_in (1): data-memory stage cannot accept.
- flush (1): kill in-flight instruction.
REQ-005 SHALL have output ready_out (1), combinational: stage can accept this cycle.
REQ-006 SHALL have EX/MEM register outputs:
- valid_out (1), opcode_out (4), rd_out (3).
- alu_output (8): result.
- address_output (8): memory address.
- store_data_output (8): store data.
- we_output (1): memory write enable.
REQ-007 SHALL have outputs zero_flag (1) and carry_flag (1), both registered.
REQ-008 SHALL, under EX_STG_FWD_EN only, have inputs fwd_data (8), fwd_sel_a (1) and fwd_sel_b (1).

Function
REQ-009 SHALL decode opcodes:
- 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT A.
- 0111 MUL (low byte), 1000 SHL A by 1, 1001 SHR A by 1, 1010 MOV B.
- 1101 LOAD, 1110 STORE.
- 0000 and all others are NOP.
REQ-010 SHALL accept an instruction on a rising edge where valid_in=1 and ready_out=1.
REQ-011 SHALL drive ready_out=1 only when state=IDLE, stall_in=0 and rst=0.
REQ-012 SHALL register non-MUL results into the EX/MEM register on the accepting edge (1-cycle latency).
REQ-013 SHALL load valid_out=0 on any non-stalled edge with no acceptance.
REQ-014 SHALL set address_output=operand_b and store_data_output=operand_a for every accepted instruction.
REQ-015 SHALL set we_output=1 only for an accepted STORE.
REQ-016 SHALL use an FSM with states IDLE, MUL and HOLD.
REQ-017 On MUL acceptance: IDLE->MUL, latch operands, counter=0, and load a bubble (valid_out=0) unless stalled.
REQ-018 In MUL: one shift-add step per edge, regardless of stall_in.
REQ-019 After 8 steps, if stall_in=0, SHALL write the result (valid_out=1) and go MUL->IDLE; MUL latency is 8 edges after acceptance.
REQ-020 After 8 steps with stall_in=1: MUL->HOLD, result retained; HOLD->IDLE with result write on the first edge where stall_in=0.
REQ-021 While stall_in=1, SHALL hold all EX/MEM outputs and flags unchanged.
REQ-022 Flush SHALL take priority over stall; on a flush edge:
- valid_out=0, we_output=0, FSM->IDLE.
- any MUL is aborted.
- flags unchanged, nothing accepted.
REQ-023 Arithmetic SHALL be 8-bit wrapping; MUL result is the low 8 bits of A*B.
REQ-024 Flag updates (only when a valid ADD/SUB/AND/OR/XOR/NOT/SHL/SHR/MUL result is written; MOV/LOAD/STORE/NOP leave flags unchanged):
- zero_flag = (result==0).
- carry_flag = carry-out (ADD), borrow A<B (SUB), A[7] (SHL), A[0] (SHR), (product[15:8]!=0) (MUL), 0 (logic ops).

Reset
REQ-025 On an edge with rst=1:
- all registered outputs = 0; FSM=IDLE, counter=0.
- ready_out=0 while rst=1.
REQ-026 Reset SHALL take priority over flush, stall and an in-progress MUL.

Configuration
REQ-027 Macro EX_STG_FWD_EN defined: the effective operand A is fwd_data when fwd_sel_a=1, else operand_a; the same rule applies to B with fwd_sel_b/operand_b. Muxing is combinational before ALU and latching.
REQ-028 Macro EX_STG_FWD_EN undefined: the forwarding ports are absent and operand_a/operand_b are used directly.

Verification
REQ-029 ADD A=8'hF0, B=8'h10, valid_in=1 -> next edge: alu_output=8'h00, zero_flag=1, carry_flag=1, valid_out=1.
REQ-030 STORE A=8'hA9, B=8'h01 -> we_output=1, address_output=8'h01, store_data_output=8'hA9; following LOAD B=8'h01 -> we_output=0, opcode_out=4'b1101.
REQ-031 MUL A=8'h13, B=8'h0B -> ready_out=0 for 8 cycles; result edge: alu_output=8'hD1, carry_flag=0, valid_out=1; SUB A=3, B=5 -> alu_output=8'hFE, carry_flag=1.
REQ-032 MUL with stall_in=1 from cycle 5 to 12 -> FSM in HOLD, outputs frozen; stall release -> result written on the next edge.
REQ-033 Flush during MUL step 4 -> valid_out=0, ready_out=1 next cycle; rst mid-MUL -> all outputs 0.
REQ-034 EX_STG_FWD_EN, fwd_sel_a=1, fwd_data=8'h22, operand_a=8'h00, ADD B=8'h01 -> alu_output=8'h23.
